alu_result_stage: RTL and testbench

//  Registered output stage directly downstream of the N-bit ripple adder in the 4-bit ALU.
//  - Captures sum/cout/overflow and derives the N,Z,C,V flags.
//  - Buffers results in a 2-entry skid FIFO under a valid/ready handshake.
//  - Consumer is the display / flag-LED logic; it may stall without losing results.

---
 rtl/alu_result_stage.sv | 148 ++++++++++++++
 tb/tb_alu_result_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// Registered output stage for the ripple adder: derives {N,Z,C,V} and buffers results in a 2-entry FIFO.
// Optional feature macro STICKY_FLAGS_EN adds sticky_flags / sticky_clr accumulation of accepted flags.
module alu_result_stage #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_sum,
    input  logic         in_cout,
    input  logic         in_overflow,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_result,
    output logic [3:0]   out_flags,
    output logic [1:0]   occupancy
`ifdef STICKY_FLAGS_EN
    ,
    output logic [3:0]   sticky_flags,
    input  logic         sticky_clr
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t       state_p1;
    state_t       state_next;
    logic [N-1:0] head_result_p1;
    logic [N-1:0] tail_result_p1;
    logic [3:0]   head_flags_p1;
    logic [3:0]   tail_flags_p1;
    logic [3:0]   new_flags;
    logic         load_head;
    logic         load_tail;
    logic         promote;

    function automatic logic [3:0] derive_flags(input logic [N-1:0] sum,
                                                input logic         cout,
                                                input logic         ovf);
        return {sum[N-1], (sum == '0), cout, ovf};
    endfunction

    assign new_flags = derive_flags(in_sum, in_cout, in_overflow);

    // Stage p1: occupancy state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p1 <= EMPTY;
        end else begin
            state_p1 <= state_next;
        end
    end

    // Next state is written from raw inputs per state so no path runs back through in_ready/out_valid
    always_comb begin
        state_next = state_p1;
        case (state_p1)
            EMPTY: begin
                if (in_valid) state_next = ONE;
            end
            ONE: begin
                if (in_valid && !out_ready)      state_next = FULL;
                else if (!in_valid && out_ready) state_next = EMPTY;
            end
            FULL: begin
                if (out_ready) state_next = ONE;
            end
            default: state_next = EMPTY;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        occupancy = 2'd0;
        load_head = 1'b0;
        load_tail = 1'b0;
        promote   = 1'b0;
        case (state_p1)
            EMPTY: begin
                in_ready  = 1'b1;
                load_head = in_valid;
            end
            ONE: begin
                in_ready  = 1'b1;
                out_valid = 1'b1;
                occupancy = 2'd1;
                load_head = in_valid & out_ready;
                load_tail = in_valid & ~out_ready;
            end
            FULL: begin
                out_valid = 1'b1;
                occupancy = 2'd2;
                promote   = out_ready;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Stage p1: head entry drives the outputs directly and holds its value once drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_result_p1 <= '0;
            head_flags_p1  <= '0;
        end else if (load_head) begin
            head_result_p1 <= in_sum;
            head_flags_p1  <= new_flags;
        end else if (promote) begin
            head_result_p1 <= tail_result_p1;
            head_flags_p1  <= tail_flags_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (load_tail) begin
            tail_result_p1 <= in_sum;
            tail_flags_p1  <= new_flags;
        end
    end

    assign out_result = head_result_p1;
    assign out_flags  = head_flags_p1;

`ifdef STICKY_FLAGS_EN
    logic accept;

    assign accept = in_valid & in_ready;

    // Clear takes priority, but a same-cycle accept still lands in the freshly cleared value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_flags <= 4'b0000;
        end else if (sticky_clr) begin
            sticky_flags <= accept ? new_flags : 4'b0000;
        end else if (accept) begin
            sticky_flags <= sticky_flags | new_flags;
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: driver pushes expected entries, negedge monitor pops and compares.
module tb_alu_result_stage;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic [N-1:0] in_sum = '0;
    logic         in_cout = 1'b0;
    logic         in_overflow = 1'b0;
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic [N-1:0] out_result;
    logic [3:0]   out_flags;
    logic [1:0]   occupancy;
`ifdef STICKY_FLAGS_EN
    logic [3:0]   sticky_flags;
    logic         sticky_clr = 1'b0;
    logic [3:0]   sticky_model = 4'b0000;
`endif

    int             checks = 0;
    int             errors = 0;
    logic [N+3:0]   exp_q[$];
    int             held = 0;
    logic [N-1:0]   last_res = '0;
    logic [3:0]     last_flg = '0;

    alu_result_stage #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sum      (in_sum),
        .in_cout     (in_cout),
        .in_overflow (in_overflow),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_flags   (out_flags),
        .occupancy   (occupancy)
`ifdef STICKY_FLAGS_EN
        ,
        .sticky_flags(sticky_flags),
        .sticky_clr  (sticky_clr)
`endif
    );

    always #5 clk = ~clk;

    // Flags from arithmetic meaning: negative in two's complement, zero, carry, overflow
    function automatic logic [3:0] ref_flags(input int sum, input bit cout, input bit ovf);
        bit neg;
        neg = (sum >= (1 << (N - 1)));
        return {neg, (sum == 0), cout, ovf};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Offer one result, hold it until accepted; called and returns at posedge+1
    task automatic push(input logic [N-1:0] s, input logic c, input logic v);
        bit done;
        done = 1'b0;
        in_valid    = 1'b1;
        in_sum      = s;
        in_cout     = c;
        in_overflow = v;
        for (int k = 0; k < 40 && !done; k++) begin
            #1;
            if (in_ready) begin
                exp_q.push_back({s, ref_flags(int'(s), c, v)});
                done = 1'b1;
            end
            cycle();
        end
        in_valid = 1'b0;
        if (!done) check("push_timeout", 32'd0, 32'd1);
    endtask

    // Monitor: inputs are stable here, so this cycle's handshakes are known exactly
    always @(negedge clk) begin
        bit           acc;
        bit           pop;
        logic [N+3:0] item;
        if (!rst_n) begin
            held     = 0;
            last_res = '0;
            last_flg = '0;
`ifdef STICKY_FLAGS_EN
            sticky_model = 4'b0000;
            check("rst_sticky", 32'(sticky_flags), 32'd0);
`endif
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_occupancy", 32'(occupancy), 32'd0);
            check("rst_in_ready", 32'(in_ready), 32'd1);
            check("rst_out_flags", 32'(out_flags), 32'd0);
            check("rst_out_result", 32'(out_result), 32'd0);
        end else begin
            check("occupancy", 32'(occupancy), 32'(held));
            check("in_ready", 32'(in_ready), 32'(held < 2));
            check("out_valid", 32'(out_valid), 32'(held > 0));
            if (held == 0) begin
                check("hold_result", 32'(out_result), 32'(last_res));
                check("hold_flags", 32'(out_flags), 32'(last_flg));
            end
            acc = in_valid && (held < 2);
            pop = (held > 0) && out_ready;
            if (pop) begin
                if (exp_q.size() == 0) begin
                    check("queue_underrun", 32'd0, 32'd1);
                end else begin
                    item = exp_q.pop_front();
                    check("out_result", 32'(out_result), 32'(item[N+3:4]));
                    check("out_flags", 32'(out_flags), 32'(item[3:0]));
                    last_res = item[N+3:4];
                    last_flg = item[3:0];
                end
            end
`ifdef STICKY_FLAGS_EN
            check("sticky_flags", 32'(sticky_flags), 32'(sticky_model));
            if (sticky_clr)
                sticky_model = acc ? ref_flags(int'(in_sum), in_cout, in_overflow) : 4'b0000;
            else if (acc)
                sticky_model = sticky_model | ref_flags(int'(in_sum), in_cout, in_overflow);
`endif
            held = held + int'(acc) - int'(pop);
        end
    end

    initial begin
        bit accepted;

        // Reset held low while the upstream offers data
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_sum   = 4'hF;
        #1;
        check("rst_direct_valid", 32'(out_valid), 32'd0);
        repeat (3) cycle();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        cycle();

        // Single zero result with carry
        out_ready = 1'b1;
        push(4'h0, 1'b1, 1'b0);
        repeat (2) cycle();

        // Fill to two, then a third offer must be held off
        out_ready = 1'b0;
        push(4'h7, 1'b0, 1'b0);
        push(4'h9, 1'b0, 1'b1);
        in_valid = 1'b1;
        in_sum   = 4'h3;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("full_in_ready", 32'(in_ready), 32'd0);
            check("full_occupancy", 32'(occupancy), 32'd2);
            cycle();
        end
        out_ready = 1'b1;
        push(4'h3, 1'b0, 1'b0);
        repeat (3) cycle();

        // Back-to-back streaming
        for (int i = 0; i < 16; i++)
            push(4'($urandom_range(15)), 1'($urandom_range(1)), 1'($urandom_range(1)));
        repeat (3) cycle();

        // Asynchronous reset while full
        out_ready = 1'b0;
        push(4'h5, 1'b0, 1'b0);
        push(4'hA, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_occupancy", 32'(occupancy), 32'd0);
        exp_q.delete();
        cycle();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        push(4'h6, 1'b0, 1'b0);
        repeat (3) cycle();

        // Random traffic with back-pressure
        for (int i = 0; i < 300; i++) begin
            accepted = 1'b0;
            if (!in_valid && $urandom_range(3) != 0) begin
                in_valid    = 1'b1;
                in_sum      = 4'($urandom_range(15));
                in_cout     = 1'($urandom_range(1));
                in_overflow = 1'($urandom_range(1));
            end
            out_ready = ($urandom_range(2) != 0);
`ifdef STICKY_FLAGS_EN
            sticky_clr = ($urandom_range(7) == 0);
`endif
            #1;
            if (in_valid && in_ready) begin
                exp_q.push_back({in_sum, ref_flags(int'(in_sum), in_cout, in_overflow)});
                accepted = 1'b1;
            end
            cycle();
            if (accepted) in_valid = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
`ifdef STICKY_FLAGS_EN
        sticky_clr = 1'b0;
`endif
        repeat (4) cycle();
        check("drain_empty", 32'(exp_q.size()), 32'd0);

`ifdef STICKY_FLAGS_EN
        // Sticky accumulation, then clear coinciding with a carry-only result
        sticky_clr = 1'b1;
        cycle();
        sticky_clr = 1'b0;
        push(4'h0, 1'b0, 1'b0);
        push(4'h8, 1'b0, 1'b1);
        check("sticky_or", 32'(sticky_flags), 32'h0000000D);
        sticky_clr = 1'b1;
        push(4'h1, 1'b1, 1'b0);
        sticky_clr = 1'b0;
        check("sticky_clr_push", 32'(sticky_flags), 32'h00000002);
        repeat (3) cycle();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
